cmp_sched: RTL and testbench
============================

Name: cmp_sched

Overview:
- Shared compare-unit scheduler for the processor.
- Accepts compare requests from two contexts: main (m_) and interrupt (i_).
- Arbitrates between them, reads register operands through a single shared register-file read port over two cycles, and performs a signed 16-bit compare.
- Writes the lt/gt/eq result into a per-context flag bank; the `inter` input selects which bank drives the flag outputs used by branch logic.

Parameters:
MAX_WAIT, 2, consecutive interrupt grants allowed while m_req is pending before main is forced to win (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
inter  in  1  current execution context; 0 = main bank drives flags, 1 = interrupt bank drives flags
m_req  in  1  main compare request; held until m_ack
m_num1  in  2  main first operand register index
m_num2  in  2  main second operand register index
m_arg  in  16  main immediate; used when m_num1 == m_num2
m_ack  out  1  one-cycle accept pulse to main
m_done  out  1  one-cycle pulse; main flags written at the end of this cycle
i_req, i_num1, i_num2, i_arg, i_ack, i_done  same widths/meaning for the interrupt context
rf_sel  out  2  register-file read index (sreg1..sreg4 = 0..3)
rf_data  in  16  combinational read data for rf_sel, same cycle
busy  out  1  high in every state except IDLE
lt  out  1  selected bank: operand A < operand B (signed)
gt  out  1  selected bank: A > B (signed)
eq  out  1  selected bank: A == B

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - Both flag banks clear to 000; starvation counter clears to 0.
  - Latched request fields clear.
  - m_ack, i_ack, m_done, i_done, busy and rf_sel are all 0.
  - An operation in flight is abandoned; no done pulse is produced.
- FSM states: IDLE -> RD_A -> RD_B -> CMP -> IDLE. Fixed 4-cycle occupancy; no back-to-back accept from CMP.
- IDLE:
  - If any request is high: arbitrate, pulse the winner's ack, latch ctx/num1/num2/arg, go to RD_A.
  - Otherwise stay in IDLE.
- Arbitration:
  - i wins ties unless starve_cnt == MAX_WAIT, in which case m wins.
  - starve_cnt increments when i is granted while m_req is high.
  - starve_cnt clears when m is granted, or in any IDLE cycle with m_req low.
  - starve_cnt saturates at MAX_WAIT.
- Request handshake:
  - Fields are sampled only in the ack cycle.
  - A request dropped before ack has no effect.
  - Requester must deassert req, or present a new request, the cycle after ack; if req stays high it is treated as a new request.
- RD_A: rf_sel = num1; opA <= rf_data.
- RD_B:
  - rf_sel = num2.
  - opB <= (num1 == num2) ? arg : rf_data.
  - In immediate mode rf_sel = num1 in both read cycles.
- CMP:
  - Signed compare of opA and opB; exactly one of lt/gt/eq is set.
  - The latched context's bank is written at the clock edge ending CMP; the other bank is untouched.
  - ctx's done pulses during CMP.
- Latency: ack at cycle T, rf_sel = num1 at T+1, rf_sel = num2 at T+2, done at T+3, new flags visible from T+4, next accept no earlier than T+4.
- Flag outputs:
  - Combinational: inter ? bank1 : bank0.
  - Toggling inter switches the outputs in the same cycle and never alters bank contents.
- Register value changes between RD_A and RD_B are tolerated: each operand is the value present in its own read cycle.
- rf_sel is 0 in IDLE and CMP.

Decomposition:
- Shared package cmp_pkg:
  - state enum (IDLE, RD_A, RD_B, CMP)
  - context encoding CTX_MAIN = 0, CTX_INT = 1
  - flag struct {lt, gt, eq}
  - FLAGS_RST = 3'b000
- One sub-module: cmp_arb, containing the two-requester priority arbiter with starvation counter. It outputs grant_valid and grant_ctx, and has an update strobe driven by the IDLE accept.

Test Plan:
1. rst low for 3 cycles with both reqs high -> all outputs 0, no ack; after release, i_ack in the first cycle.
2. inter=0; m_req with num1=1, num2=2, R1=0xFFFF, R2=0x0001 -> m_ack at T, rf_sel=1 at T+1, rf_sel=2 at T+2, m_done at T+3; from T+4 lt/gt/eq=1/0/0; with inter=1 the outputs read 0/0/0.
3. inter=1; i_req with num1=num2=3, R3=0x8000, i_arg=0x8000 -> rf_sel=3 at T+1 and T+2, eq=1 in bank1; bank0 unchanged.
4. MAX_WAIT=2, m_req and i_req held high continuously -> grant order i, i, m, i, i, m with grants 4 cycles apart.
5. Signed boundary: R0=0x7FFF vs R1=0x8000 -> gt=1; swapping the operands -> lt=1.
6. rst pulsed low during RD_B of a main request -> no m_done, bank0 = 000; the still-held m_req is re-accepted after release with full latency.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the compare-unit scheduler: FSM states,
// context encoding, the lt/gt/eq flag record and the signed compare itself.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    CMP  = 2'd3
  } state_e;

  localparam logic CTX_MAIN = 1'b0;
  localparam logic CTX_INT  = 1'b1;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } flags_t;

  localparam flags_t FLAGS_RST = 3'b000;

  // Starvation counter width; covers the full 1..15 range of MAX_WAIT.
  localparam int unsigned WAIT_W = 4;

  function automatic flags_t cmp16(input logic [15:0] a, input logic [15:0] b);
    flags_t f;
    f.lt = $signed(a) <  $signed(b);
    f.gt = $signed(a) >  $signed(b);
    f.eq = (a == b);
    return f;
  endfunction

endpackage

// File: rtl/cmp_arb.sv
// Two-requester arbiter: the interrupt context wins ties until main has been
// passed over MAX_WAIT times in a row, after which main is forced through.
module cmp_arb
  import cmp_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic m_req,
  input  logic i_req,
  input  logic idle,
  input  logic update,
  output logic grant_valid,
  output logic grant_ctx
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] starve_q, starve_d;
  logic              m_forced;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    m_forced    = m_req && (starve_q == MAX_CNT);
    grant_valid = m_req || i_req;
    grant_ctx   = (i_req && !m_forced) ? CTX_INT : CTX_MAIN;
    starve_d    = starve_q;
    if (idle && !m_req) begin
      starve_d = '0;
    end else if (update) begin
      if (grant_ctx == CTX_MAIN) begin
        starve_d = '0;
      end else if (starve_q != MAX_CNT) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/cmp_sched.sv
// Shared compare-unit scheduler: accepts a request, reads both operands over
// the single register-file port, compares them signed and updates the bank.
module cmp_sched
  import cmp_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inter,
  input  logic        m_req,
  input  logic [1:0]  m_num1,
  input  logic [1:0]  m_num2,
  input  logic [15:0] m_arg,
  output logic        m_ack,
  output logic        m_done,
  input  logic        i_req,
  input  logic [1:0]  i_num1,
  input  logic [1:0]  i_num2,
  input  logic [15:0] i_arg,
  output logic        i_ack,
  output logic        i_done,
  output logic [1:0]  rf_sel,
  input  logic [15:0] rf_data,
  output logic        busy,
  output logic        lt,
  output logic        gt,
  output logic        eq
);

  state_e      state_q;
  logic        run_q;
  logic        ctx_q;
  logic [1:0]  num1_q, num2_q;
  logic [15:0] arg_q, op_a_q, op_b_q;
  flags_t      bank0_q, bank1_q;
  flags_t      res, sel_flags;
  logic        idle, accept, grant_valid, grant_ctx;

  assign idle   = (state_q == IDLE);
  // run_q keeps acks quiet while reset is held, without feeding rst into logic.
  assign accept = run_q && idle && grant_valid;

  cmp_arb #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .m_req       (m_req),
    .i_req       (i_req),
    .idle        (idle),
    .update      (accept),
    .grant_valid (grant_valid),
    .grant_ctx   (grant_ctx)
  );

  always_comb begin
    m_ack     = accept && (grant_ctx == CTX_MAIN);
    i_ack     = accept && (grant_ctx == CTX_INT);
    m_done    = (state_q == CMP) && (ctx_q == CTX_MAIN);
    i_done    = (state_q == CMP) && (ctx_q == CTX_INT);
    busy      = !idle;
    res       = cmp16(op_a_q, op_b_q);
    sel_flags = inter ? bank1_q : bank0_q;
    lt        = sel_flags.lt;
    gt        = sel_flags.gt;
    eq        = sel_flags.eq;
    unique case (state_q)
      RD_A:    rf_sel = num1_q;
      RD_B:    rf_sel = num2_q;
      default: rf_sel = 2'd0;
    endcase
  end

  // NOTE: the flag banks are architectural state read by branch logic, so
  // they sit on the async reset like the control flops rather than staying X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      ctx_q   <= CTX_MAIN;
      num1_q  <= '0;
      num2_q  <= '0;
      arg_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      bank0_q <= FLAGS_RST;
      bank1_q <= FLAGS_RST;
    end else begin
      run_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            ctx_q   <= grant_ctx;
            num1_q  <= (grant_ctx == CTX_INT) ? i_num1 : m_num1;
            num2_q  <= (grant_ctx == CTX_INT) ? i_num2 : m_num2;
            arg_q   <= (grant_ctx == CTX_INT) ? i_arg  : m_arg;
            state_q <= RD_A;
          end
        end
        RD_A: begin
          op_a_q  <= rf_data;
          state_q <= RD_B;
        end
        RD_B: begin
          // Equal indices select immediate mode: the second operand is arg.
          op_b_q  <= (num1_q == num2_q) ? arg_q : rf_data;
          state_q <= CMP;
        end
        CMP: begin
          if (ctx_q == CTX_INT) bank1_q <= res;
          else                  bank0_q <= res;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// Scoreboard bench for cmp_sched: stimulus queues each expected grant, a
// monitor checks ack context, read indices, done timing and grant spacing.
module tb_cmp_sched;
  import cmp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inter = 1'b0;
  logic        m_req = 1'b0, i_req = 1'b0;
  logic [1:0]  m_num1 = '0, m_num2 = '0, i_num1 = '0, i_num2 = '0;
  logic [15:0] m_arg = '0, i_arg = '0;
  logic        m_ack, m_done, i_ack, i_done, busy, lt, gt, eq;
  logic [1:0]  rf_sel;
  logic [15:0] rf_data;
  logic [15:0] rf [4];

  assign rf_data = rf[rf_sel];
  always #5 clk = ~clk;

  cmp_sched #(.MAX_WAIT(2)) dut (
    .clk(clk), .rst(rst), .inter(inter),
    .m_req(m_req), .m_num1(m_num1), .m_num2(m_num2), .m_arg(m_arg),
    .m_ack(m_ack), .m_done(m_done),
    .i_req(i_req), .i_num1(i_num1), .i_num2(i_num2), .i_arg(i_arg),
    .i_ack(i_ack), .i_done(i_done),
    .rf_sel(rf_sel), .rf_data(rf_data), .busy(busy),
    .lt(lt), .gt(gt), .eq(eq)
  );

  typedef struct {
    logic       ctx;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    int         gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic ctx, input logic [1:0] a, input logic [1:0] b, input int gap);
    exp_t e;
    e.ctx = ctx; e.sel_a = a; e.sel_b = b; e.gap = gap;
    sb_q.push_back(e);
  endtask

  // Monitor: every ack pops one expected grant and follows it to its done.
  initial begin
    exp_t e;
    time  last_t = 0;
    logic alive;
    forever begin
      @(negedge clk);
      if (!rst) continue;
      if (m_ack || i_ack) begin
        check("ack_onehot", {31'd0, m_ack & i_ack}, 32'd0);
        check("ack_expected", sb_q.size(), 32'd1 + (sb_q.size() > 1 ? sb_q.size() - 1 : 0));
        if (sb_q.size() == 0) continue;
        e = sb_q.pop_front();
        check("ack_ctx", {31'd0, i_ack}, {31'd0, e.ctx});
        if (e.gap != 0) check("ack_gap", 32'(($time - last_t) / 10), e.gap);
        last_t = $time;
        alive  = 1'b1;
        @(negedge clk);
        if (!rst) alive = 1'b0;
        else check("rd_a_sel", {busy, rf_sel}, {1'b1, e.sel_a});
        if (alive) begin
          @(negedge clk);
          if (!rst) alive = 1'b0;
          else check("rd_b_sel", {busy, rf_sel}, {1'b1, e.sel_b});
        end
        if (alive) begin
          @(negedge clk);
          if (rst) check("cmp_done", {busy, m_done, i_done, rf_sel},
                         {1'b1, e.ctx == CTX_MAIN, e.ctx == CTX_INT, 2'd0});
        end
      end else begin
        check("spurious_done", {m_done, i_done}, 2'b00);
      end
    end
  end

  task automatic wait_ack(input logic ctx);
    logic got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ctx == CTX_INT ? i_ack : m_ack) begin got = 1'b1; break; end
    end
    check("ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_done(input logic ctx);
    logic got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ctx == CTX_INT ? i_done : m_done) begin got = 1'b1; break; end
    end
    check("done_timeout", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic ctx, input logic [1:0] n1, input logic [1:0] n2,
                       input logic [15:0] arg);
    push(ctx, n1, n2, 0);
    if (ctx == CTX_INT) begin i_num1 = n1; i_num2 = n2; i_arg = arg; i_req = 1'b1; end
    else                begin m_num1 = n1; m_num2 = n2; m_arg = arg; m_req = 1'b1; end
    wait_ack(ctx);
    @(posedge clk); #1;
    m_req = 1'b0; i_req = 1'b0;
    wait_done(ctx);
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp);
    check(name, {29'd0, lt, gt, eq}, {29'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rf[0] = 16'd0; rf[1] = 16'd10; rf[2] = 16'd20; rf[3] = 16'd0;

    // 1: reset with both requests high; interrupt wins first after release.
    m_num1 = 2'd0; m_num2 = 2'd3; i_num1 = 2'd1; i_num2 = 2'd2;
    m_req = 1'b1; i_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {23'd0, m_ack, i_ack, m_done, i_done, busy, rf_sel, lt, gt, eq}, 32'd0);
    end
    push(CTX_INT, 2'd1, 2'd2, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("first_grant", {30'd0, m_ack, i_ack}, 32'b01);
    @(posedge clk); #1;
    m_req = 1'b0; i_req = 1'b0;
    wait_done(CTX_INT);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;

    // 2: main compare, register operands, -1 < 1.
    rf[1] = 16'hFFFF; rf[2] = 16'h0001;
    issue(CTX_MAIN, 2'd1, 2'd2, 16'h0);
    check_flags("main_lt_bank0", 3'b100);
    inter = 1'b1; #1;
    check_flags("bank1_still_clear", 3'b000);

    // 3: interrupt immediate mode, 0x8000 == 0x8000.
    rf[3] = 16'h8000;
    issue(CTX_INT, 2'd3, 2'd3, 16'h8000);
    check_flags("int_imm_eq_bank1", 3'b001);
    inter = 1'b0; #1;
    check_flags("bank0_untouched", 3'b100);

    // Immediate operand actually replaces the second register read.
    rf[0] = 16'd5;
    issue(CTX_MAIN, 2'd0, 2'd0, 16'd3);
    check_flags("main_imm_gt", 3'b010);

    // 5: signed boundary in both operand orders.
    rf[0] = 16'h7FFF; rf[1] = 16'h8000;
    issue(CTX_MAIN, 2'd1, 2'd0, 16'h0);
    check_flags("signed_min_lt_max", 3'b100);
    issue(CTX_MAIN, 2'd0, 2'd1, 16'h0);
    check_flags("signed_max_gt_min", 3'b010);

    // 4: both held; grant order i,i,m,i,i,m four cycles apart.
    push(CTX_INT, 2'd2, 2'd3, 0);  push(CTX_INT, 2'd2, 2'd3, 4);
    push(CTX_MAIN, 2'd0, 2'd1, 4); push(CTX_INT, 2'd2, 2'd3, 4);
    push(CTX_INT, 2'd2, 2'd3, 4);  push(CTX_MAIN, 2'd0, 2'd1, 4);
    m_num1 = 2'd0; m_num2 = 2'd1; i_num1 = 2'd2; i_num2 = 2'd3;
    m_req = 1'b1; i_req = 1'b1;
    acks = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_ack || i_ack) acks++;
      if (acks == 6) break;
    end
    check("burst_grants", acks, 32'd6);
    @(posedge clk); #1;
    m_req = 1'b0; i_req = 1'b0;
    wait_done(CTX_MAIN);
    check_flags("burst_last_main_gt", 3'b010);

    // 6: reset during RD_B abandons the operation; held request re-accepted.
    rf[1] = 16'd3; rf[2] = 16'd3;
    push(CTX_MAIN, 2'd1, 2'd2, 0);
    m_num1 = 2'd1; m_num2 = 2'd2; m_req = 1'b1;
    wait_ack(CTX_MAIN);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("abort_outputs", {26'd0, m_done, busy, rf_sel, lt, gt}, 32'd0);
    check_flags("abort_bank0_clear", 3'b000);
    push(CTX_MAIN, 2'd1, 2'd2, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    wait_ack(CTX_MAIN);
    @(posedge clk); #1;
    m_req = 1'b0;
    wait_done(CTX_MAIN);
    check_flags("reaccept_eq", 3'b001);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
